// File: rtl/pipe_accum_pkg.sv
// pipe_accum_pkg: shared types and default constants for the frame accumulator.
package pipe_accum_pkg;

  // Frame accumulator control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One input beat: tag [24], data [23:8], lo8 [7:0]
  typedef struct packed {
    logic        tag;
    logic [15:0] data;
    logic [7:0]  lo8;
  } beat_t;

  localparam int DEF_SUM_W     = 20;
  localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/pipe_accum_fifo.sv
// pipe_accum_fifo: 2-entry beat buffer between the input handshake and the accumulator.
// The read port is a plain mux of the head entry, so a beat pushed at one edge
// can be popped at the very next edge.
module pipe_accum_fifo
  import pipe_accum_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  beat_t wr_data,
  input  logic  pop,
  output beat_t rd_data,
  output logic  full,
  output logic  empty
);

  beat_t      mem [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] cnt_reg;
  logic       do_push;
  logic       do_pop;

  assign full    = (cnt_reg == 2'd2);
  assign empty   = (cnt_reg == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage write; contents are meaningless while the count says empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset empties the buffer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      cnt_reg    <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + 2'd1;
        2'b01:   cnt_reg <= cnt_reg - 2'd1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/pipe_accum.sv
// pipe_accum: sums in_data, counts beats and XOR-folds in_lo8 per frame.
// A frame closes on a tagged beat or after MAX_BEATS beats; the result is held
// until the downstream handshake. Define PIPE_ACCUM_OVF_EN to add the out_ovf
// carry-out flag; without it the sum wraps silently.
module pipe_accum
  import pipe_accum_pkg::*;
#(
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int SUM_W     = DEF_SUM_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_tag,
  input  logic [15:0]      in_data,
  input  logic [7:0]       in_lo8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [4:0]       out_count,
  output logic [7:0]       out_xor8
`ifdef PIPE_ACCUM_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  state_t           state_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [4:0]       count_reg;
  logic [7:0]       xor_reg;
  logic             valid_reg;

  beat_t            wr_beat;
  beat_t            head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  logic [SUM_W-1:0] base_sum;
  logic [4:0]       base_count;
  logic [7:0]       base_xor;
  logic [SUM_W-1:0] data_ext;
  logic [SUM_W-1:0] sum_next;
  logic [4:0]       count_next;
  logic [7:0]       xor_next;
  logic             close;

  assign wr_beat  = '{tag: in_tag, data: in_data, lo8: in_lo8};
  assign in_ready = !fifo_full;
  // Pops are frozen while a result is waiting for the downstream handshake
  assign pop      = (state_reg != HOLD) && !fifo_empty;

  pipe_accum_fifo u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (in_valid),
    .wr_data (wr_beat),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next frame values: a pop from IDLE starts from a cleared accumulator
  always_comb begin
    data_ext       = '0;
    data_ext[15:0] = head.data;
    base_sum       = (state_reg == IDLE) ? '0 : sum_reg;
    base_count     = (state_reg == IDLE) ? 5'd0 : count_reg;
    base_xor       = (state_reg == IDLE) ? 8'd0 : xor_reg;
    count_next     = base_count + 5'd1;
    xor_next       = base_xor ^ head.lo8;
    close          = head.tag || (count_next == 5'(MAX_BEATS));
  end

`ifdef PIPE_ACCUM_OVF_EN
  logic [SUM_W:0] sum_ext;
  logic           ovf_reg;
  logic           ovf_next;

  // Carry-out of each add is sticky for the rest of the frame
  always_comb begin
    sum_ext  = {1'b0, base_sum} + {1'b0, data_ext};
    sum_next = sum_ext[SUM_W-1:0];
    ovf_next = ((state_reg == IDLE) ? 1'b0 : ovf_reg) | sum_ext[SUM_W];
  end

  assign out_ovf = ovf_reg;

  // Overflow flag tracks the frame alongside the accumulator
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_reg <= 1'b0;
    end else if (pop) begin
      ovf_reg <= ovf_next;
    end
  end
`else
  // Plain modular add
  always_comb begin
    sum_next = base_sum + data_ext;
  end
`endif

  assign out_valid = valid_reg;
  assign out_sum   = sum_reg;
  assign out_count = count_reg;
  assign out_xor8  = xor_reg;

  // Frame FSM with registered result; accumulator doubles as the output register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      sum_reg   <= '0;
      count_reg <= 5'd0;
      xor_reg   <= 8'd0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACC: begin
          if (pop) begin
            sum_reg   <= sum_next;
            count_reg <= count_next;
            xor_reg   <= xor_next;
            if (close) begin
              state_reg <= HOLD;
              valid_reg <= 1'b1;
            end else begin
              state_reg <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
